piano_track_scheduler: RTL
==========================

# piano_track_scheduler

Parametrised track register bank for the piano driver. It holds the current note of each of `NUM_TRACKS` independent tracks and accepts one command per cycle through a valid/ready handshake. Each note carries an optional duration: the block counts it down in prescaled ticks and releases the track to rest (note 0) when it expires. The block sits between the MMIO piano command port and the tone generators, which read the flattened note bus and the per-track active bitmap.

## Interface
- `NUM_TRACKS`, 4, number of tracks; 1..16
- `NOTE_WIDTH`, 6, bits per note code; code 0 = rest
- `DUR_WIDTH`, 8, bits of the duration field, in ticks
- `TICK_DIV`, 100000, clock cycles per duration tick; ≥2
- `TRACK_W`, derived: clog2(NUM_TRACKS), minimum 1
- `iFpgaClock` in 1: sole clock, rising edge
- `iFpgaReset` in 1: asynchronous, active-high reset
- `iCmdValid` in 1: command present
- `oCmdReady` out 1: block can accept a command
- `iCmdTrack` in TRACK_W: target track index
- `iCmdNote` in NOTE_WIDTH: note code to load
- `iCmdDuration` in DUR_WIDTH: hold time in ticks; 0 = sustain until overwritten
- `iStopAll` in 1: single-cycle pulse that silences every track
- `oTrackNotes` out NUM_TRACKS*NOTE_WIDTH: track k occupies bits [k*NOTE_WIDTH +: NOTE_WIDTH]
- `oTrackActive` out NUM_TRACKS: bit k is 1 when track k holds a nonzero note
- `oTick` out 1: one-cycle duration tick strobe, for debug and test

## Operation
- Per-track state: `note[k]` (NOTE_WIDTH), `remain[k]` (DUR_WIDTH). `oTrackActive[k]` = (note[k] != 0), registered.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `oTick` = 1 in the cycle the count equals TICK_DIV-1.
- Accept: a command is accepted when iCmdValid & oCmdReady. `oCmdReady` is 0 while iStopAll is high and 1 at all other times after reset.
- On accept: note[t] <= iCmdNote and remain[t] <= iCmdDuration.
  - iCmdNote = 0 forces remain[t] <= 0, so the track rests.
  - A track index ≥ NUM_TRACKS is accepted and discarded. No state changes.
- On tick, for each track k not written this cycle:
  - remain[k] > 1: decrement.
  - remain[k] == 1: remain <= 0 and note <= 0 (release).
  - remain[k] == 0: unchanged (sustain or rest).
- iStopAll: every note and remain is set to 0. The prescaler is unaffected.
- Priority within a cycle: iStopAll, then accepted command, then tick countdown. A command to a track whose timer expires on the same tick loads the new note and duration, with no decrement that cycle. Other tracks still count down normally.
- Reset: all note, remain and prescaler values = 0. oTrackNotes = 0, oTrackActive = 0, oTick = 0, oCmdReady = 0 while iFpgaReset is high and 1 from the first edge after release. Reset asserted mid-note clears that note immediately (asynchronously).

## Timing
- Write latency: the command is accepted at edge N, and oTrackNotes / oTrackActive show the new value after edge N; they are stable for the whole of cycle N+1.
- Duration D ≥ 1 accepted at edge N: the track releases on the D-th tick edge after N. Hold time is between (D-1)*TICK_DIV+1 and D*TICK_DIV cycles, depending on prescaler phase.
- Release is visible one cycle after the tick cycle.
- Back-to-back commands are allowed every cycle with no bubble.
- Ticks are periodic, TICK_DIV cycles apart, counted from reset release.
- All outputs come straight from registers; there is no combinational input-to-output path except iStopAll → oCmdReady.

## Test plan
- Reset: hold iFpgaReset high mid-simulation after loading notes → all outputs read 0 asynchronously; oCmdReady = 1 on the first edge after release.
- Sustain (NUM_TRACKS=4, TICK_DIV=4): write track 2, note 0x15, duration 0 → oTrackNotes[17:12] = 0x15 and oTrackActive = 4'b0100; the note stays through 20 ticks.
- Timed release: write track 1, note 0x2A, duration 3, right after a tick → the note is present for 3 ticks and returns to 0 the cycle after the third tick; oTrackActive[1] falls at the same time.
- Collision: track 0 has remain = 1, then a write to track 0 (note 0x07, duration 2) lands in the tick cycle → the note becomes 0x07, not 0, and releases 2 ticks later. Track 3 (remain 1) releases on that same tick.
- Stop-all: pulse iStopAll with iCmdValid asserted for track 1 → oCmdReady = 0 that cycle, the command is not accepted, and all tracks read 0 next cycle.
- Range and back-to-back (NUM_TRACKS=3): write track 3 → no change. Then four consecutive cycles writing tracks 0, 1, 2, 0 with notes 1, 2, 3, 4 → final notes are {3, 2, 4} for tracks 2, 1, 0.

Source files
------------

// File: rtl/piano_track_scheduler_if.sv
// piano_track_scheduler_if
//   Command port of the piano track scheduler.
//
//   Handshake: a command transfers on a rising clock edge where iCmdValid
//   and oCmdReady are both high. The master holds iCmdTrack/iCmdNote/
//   iCmdDuration stable while iCmdValid is high and not yet accepted.
//   oCmdReady may drop combinationally while iStopAll is high; no command
//   transfers in that cycle.
//
//   Signals:
//     iCmdValid    master -> slave  command present
//     oCmdReady    slave  -> master command can be accepted this cycle
//     iCmdTrack    master -> slave  target track index (TRACK_W bits)
//     iCmdNote     master -> slave  note code, 0 = rest (NOTE_WIDTH bits)
//     iCmdDuration master -> slave  hold time in ticks, 0 = sustain
//     iStopAll     master -> slave  one-cycle pulse silencing all tracks
interface piano_track_scheduler_if #(
  parameter int TRACK_W    = 2,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 8
);
  logic                  iCmdValid;
  logic                  oCmdReady;
  logic [TRACK_W-1:0]    iCmdTrack;
  logic [NOTE_WIDTH-1:0] iCmdNote;
  logic [DUR_WIDTH-1:0]  iCmdDuration;
  logic                  iStopAll;

  modport master (
    output iCmdValid,
    output iCmdTrack,
    output iCmdNote,
    output iCmdDuration,
    output iStopAll,
    input  oCmdReady
  );

  modport slave (
    input  iCmdValid,
    input  iCmdTrack,
    input  iCmdNote,
    input  iCmdDuration,
    input  iStopAll,
    output oCmdReady
  );
endinterface

// File: rtl/piano_track_scheduler.sv
// piano_track_scheduler
//   Register bank holding the current note of NUM_TRACKS tracks. One
//   command per cycle loads a note and an optional duration into a track;
//   durations count down in prescaled ticks (TICK_DIV clocks each) and the
//   track falls back to rest (note 0) when its duration runs out.
//
//   Ports:
//     iFpgaClock   in   sole clock, rising edge
//     iFpgaReset   in   asynchronous active-high reset
//     cmd          if   command port (slave modport), see the interface
//     oTrackNotes  out  flattened notes, track k at [k*NOTE_WIDTH +: NOTE_WIDTH]
//     oTrackActive out  bit k set while track k holds a nonzero note
//     oTick        out  one-cycle duration tick strobe
//
//   Priority within a cycle: stop-all, then accepted command, then tick
//   countdown. Every output is a register except oCmdReady, which drops
//   combinationally while iStopAll is high.
module piano_track_scheduler #(
  parameter int NUM_TRACKS = 4,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 8,
  parameter int TICK_DIV   = 100000
) (
  input  logic                             iFpgaClock,
  input  logic                             iFpgaReset,
  piano_track_scheduler_if.slave           cmd,
  output logic [NUM_TRACKS*NOTE_WIDTH-1:0] oTrackNotes,
  output logic [NUM_TRACKS-1:0]            oTrackActive,
  output logic                             oTick
);

  localparam int TRACK_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
  localparam int PRE_W   = $clog2(TICK_DIV);

  // Per-track state
  logic [NOTE_WIDTH-1:0] note_q   [NUM_TRACKS];
  logic [DUR_WIDTH-1:0]  remain_q [NUM_TRACKS];
  logic [NOTE_WIDTH-1:0] note_d   [NUM_TRACKS];
  logic [DUR_WIDTH-1:0]  remain_d [NUM_TRACKS];
  logic [NUM_TRACKS-1:0] active_q;

  // Prescaler and tick
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_q;

  // Handshake
  logic ready_q;
  logic ready;
  logic accept;

  // ready_q is 0 only while reset is held, so the block refuses commands
  // during reset and accepts from the first edge after release.
  assign ready         = ready_q & ~cmd.iStopAll;
  assign cmd.oCmdReady = ready;
  assign accept        = cmd.iCmdValid & ready;

  // Next-state of every track. A track index outside 0..NUM_TRACKS-1
  // matches no k below, so such a command is accepted and dropped.
  always_comb begin
    for (int k = 0; k < NUM_TRACKS; k++) begin
      note_d[k]   = note_q[k];
      remain_d[k] = remain_q[k];
      if (cmd.iStopAll) begin
        note_d[k]   = '0;
        remain_d[k] = '0;
      end else if (accept && (cmd.iCmdTrack == TRACK_W'(k))) begin
        // A written track skips this cycle's countdown; a rest command
        // carries no duration.
        note_d[k]   = cmd.iCmdNote;
        remain_d[k] = (cmd.iCmdNote == '0) ? '0 : cmd.iCmdDuration;
      end else if (tick_q) begin
        if (remain_q[k] > DUR_WIDTH'(1)) begin
          remain_d[k] = remain_q[k] - DUR_WIDTH'(1);
        end else if (remain_q[k] == DUR_WIDTH'(1)) begin
          remain_d[k] = '0;
          note_d[k]   = '0;
        end
      end
    end
  end

  always_ff @(posedge iFpgaClock or posedge iFpgaReset) begin
    if (iFpgaReset) begin
      pre_cnt  <= '0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b0;
      active_q <= '0;
      for (int k = 0; k < NUM_TRACKS; k++) begin
        note_q[k]   <= '0;
        remain_q[k] <= '0;
      end
    end else begin
      if (pre_cnt == PRE_W'(TICK_DIV - 1)) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      // Registered strobe: high exactly while pre_cnt holds TICK_DIV-1,
      // so it is set on the edge that loads that count.
      tick_q  <= (pre_cnt == PRE_W'(TICK_DIV - 2));
      ready_q <= 1'b1;
      for (int k = 0; k < NUM_TRACKS; k++) begin
        note_q[k]   <= note_d[k];
        remain_q[k] <= remain_d[k];
        active_q[k] <= (note_d[k] != '0);
      end
    end
  end

  always_comb begin
    oTrackNotes = '0;
    for (int k = 0; k < NUM_TRACKS; k++) begin
      oTrackNotes[k*NOTE_WIDTH +: NOTE_WIDTH] = note_q[k];
    end
  end

  assign oTrackActive = active_q;
  assign oTick        = tick_q;

endmodule
